// File: rtl/config_reg_bank_if.sv
// ---------------------------------------------------------------------------
// config_reg_bank_if
//   Host-side bus of the configuration register bank.
//   master : host (drives write/read/address/data_in/byte_en/commit)
//   slave  : register bank (drives data_out/rd_valid/err/cfg_flat)
//
//   Signals
//     write, read  : single-cycle request strobes, sampled every rising edge
//     address      : register select; NUM_REGS selects the LOCK register
//     data_in      : write data
//     byte_en      : per-byte write strobes
//     commit       : shadow->active copy pulse (SHADOW_COMMIT_EN builds only)
//     data_out     : registered read data, holds when rd_valid=0
//     rd_valid     : one-cycle pulse, data_out valid
//     err          : one-cycle error pulse, same slot as rd_valid
//     cfg_flat     : all active register values, continuous
//
//   Request semantics: there is no back-pressure. A request present at a
//   rising edge is always accepted; its response (rd_valid/err) appears in
//   the cycle after that edge. write and read together: write is performed,
//   read is dropped and err is flagged.
// ---------------------------------------------------------------------------
interface config_reg_bank_if #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS + 1)
);
  logic                       write;
  logic                       read;
  logic [ADDR_W-1:0]          address;
  logic [DATA_W-1:0]          data_in;
  logic [DATA_W/8-1:0]        byte_en;
  logic                       commit;
  logic [DATA_W-1:0]          data_out;
  logic                       rd_valid;
  logic                       err;
  logic [NUM_REGS*DATA_W-1:0] cfg_flat;

  modport master (
    output write, read, address, data_in, byte_en, commit,
    input  data_out, rd_valid, err, cfg_flat
  );

  modport slave (
    input  write, read, address, data_in, byte_en, commit,
    output data_out, rd_valid, err, cfg_flat
  );
endinterface

// File: rtl/config_reg_bank.sv
// ---------------------------------------------------------------------------
// config_reg_bank
//   NUM_REGS x DATA_W configuration registers with per-register reset values,
//   byte-lane write strobes, a registered read (latency 1) with valid flag,
//   sticky per-register write locks (LOCK register at address NUM_REGS) and
//   an error pulse for locked writes, out-of-range accesses and write/read
//   collisions.
//
//   Optional feature macro: SHADOW_COMMIT_EN
//     defined   : writes/locks/reads act on a shadow set; a commit pulse
//                 copies the shadow set (including a same-cycle write) to the
//                 active set driven on cfg_flat.
//     undefined : single register set, cfg_flat follows writes directly,
//                 commit is ignored.
//
//   Ports
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     bus   : config_reg_bank_if.slave (see interface file)
// ---------------------------------------------------------------------------
module config_reg_bank #(
  parameter int                         NUM_REGS   = 8,
  parameter int                         DATA_W     = 16,
  parameter int                         ADDR_W     = $clog2(NUM_REGS + 1),
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {16'h0001, 16'h0000, 16'hABCD, 16'h0000,
                                                      16'h0000, 16'h0000, 16'h0000, 16'hFFFF}
) (
  input  logic                clk,
  input  logic                reset,
  config_reg_bank_if.slave    bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Register set addressed by the host (the shadow set when commit is enabled).
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] lock_q, lock_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;

  logic                in_range;
  logic                is_lock_addr;
  logic [IDX_W-1:0]    idx;

  assign in_range     = bus.address <  ADDR_W'(NUM_REGS);
  assign is_lock_addr = bus.address == ADDR_W'(NUM_REGS);
  assign idx          = bus.address[IDX_W-1:0];

  always_comb begin
    regs_d     = regs_q;
    lock_d     = lock_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;

    if (bus.write) begin
      if (in_range) begin
        if (lock_q[idx]) begin
          // An all-zero strobe is a no-op even on a locked register.
          err_d = (bus.byte_en != '0);
        end else begin
          for (int k = 0; k < BE_W; k++) begin
            if (bus.byte_en[k]) regs_d[idx][8*k +: 8] = bus.data_in[8*k +: 8];
          end
        end
      end else if (is_lock_addr) begin
        // Locks are sticky: only OR-in, never clear outside reset.
        lock_d = lock_q | bus.data_in[NUM_REGS-1:0];
      end else begin
        err_d = 1'b1;
      end
      // A read colliding with a write is dropped and flagged.
      if (bus.read) err_d = 1'b1;
    end else if (bus.read) begin
      rd_valid_d = 1'b1;
      if (in_range) begin
        data_out_d = regs_q[idx];
      end else if (is_lock_addr) begin
        data_out_d                 = '0;
        data_out_d[NUM_REGS-1:0]   = lock_q;
      end else begin
        data_out_d = '0;
        err_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      lock_q     <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      lock_q     <= lock_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = err_q;

`ifdef SHADOW_COMMIT_EN
  // Active set seen by the consumers. Copying regs_d (not regs_q) lets a
  // write that coincides with commit land in the active set at that edge.
  logic [DATA_W-1:0] active_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) active_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
    end else if (bus.commit) begin
      active_q <= regs_d;
    end
  end

  always_comb begin
    bus.cfg_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) bus.cfg_flat[i*DATA_W +: DATA_W] = active_q[i];
  end
`else
  // Single register set: commit has no function in this build.
  logic unused_commit;
  assign unused_commit = bus.commit;

  always_comb begin
    bus.cfg_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) bus.cfg_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end
`endif

endmodule

// File: tb/tb_config_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_config_reg_bank
//   Self-checking bench for config_reg_bank. Directed scenarios followed by
//   randomized traffic, all compared against a register-array reference model.
// ---------------------------------------------------------------------------
module tb_config_reg_bank;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int FLAT_W   = NUM_REGS * DATA_W;
  localparam logic [FLAT_W-1:0] RESET_VALS = {16'h0001, 16'h0000, 16'hABCD, 16'h0000,
                                              16'h0000, 16'h0000, 16'h0000, 16'hFFFF};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  config_reg_bank_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  config_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RESET_VALS(RESET_VALS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0]   m_reg [NUM_REGS];   // host-visible set
  logic [DATA_W-1:0]   m_act [NUM_REGS];   // set seen on cfg_flat
  logic [NUM_REGS-1:0] m_lock;
  logic [DATA_W-1:0]   m_dout;
  logic [DATA_W-1:0]   exp_q [$];          // expected read data, in order

`ifdef SHADOW_COMMIT_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [FLAT_W-1:0] got, input logic [FLAT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FLAT_W-1:0] model_flat();
    logic [FLAT_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = m_act[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_reg[i] = RESET_VALS[i*DATA_W +: DATA_W];
      m_act[i] = m_reg[i];
    end
    m_lock = '0;
    m_dout = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    bus.byte_en = '0;
    bus.commit  = 1'b0;
  endtask

  // Reset pulse with a conflicting write present; reset must win.
  task automatic do_reset();
    reset       = 1'b1;
    bus.write   = 1'b1;
    bus.address = 4'd0;
    bus.data_in = 16'h1234;
    bus.byte_en = 2'b11;
    bus.commit  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    model_reset();
    check("rst_rd_valid", FLAT_W'(bus.rd_valid), '0);
    check("rst_err",      FLAT_W'(bus.err),      '0);
    check("rst_data_out", FLAT_W'(bus.data_out), '0);
    check("rst_cfg_flat", bus.cfg_flat, model_flat());
  endtask

  // One bus cycle: drive at a falling edge, let the rising edge sample it,
  // check the response at the next falling edge. Inputs are left driven so
  // consecutive calls form back-to-back cycles.
  task automatic do_op(input string tag, input logic w, input logic r, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [1:0] be, input logic c);
    logic e_err, e_rv;
    int   ai;
    bus.write = w; bus.read = r; bus.address = a; bus.data_in = d; bus.byte_en = be; bus.commit = c;
    ai    = int'(a);
    e_err = 1'b0;
    e_rv  = 1'b0;
    if (w) begin
      if (ai < NUM_REGS) begin
        if (m_lock[ai]) e_err = (be != 2'b00);
        else begin
          for (int k = 0; k < 2; k++)
            if (be[k]) m_reg[ai] = (m_reg[ai] & ~(16'hFF << (8*k))) | (d & (16'hFF << (8*k)));
        end
      end else if (ai == NUM_REGS) m_lock = m_lock | d[NUM_REGS-1:0];
      else e_err = 1'b1;
      if (r) e_err = 1'b1;
    end else if (r) begin
      e_rv = 1'b1;
      if (ai < NUM_REGS)       m_dout = m_reg[ai];
      else if (ai == NUM_REGS) m_dout = DATA_W'(m_lock);
      else begin m_dout = '0; e_err = 1'b1; end
      exp_q.push_back(m_dout);
    end
    if (!SHADOW || c) for (int i = 0; i < NUM_REGS; i++) m_act[i] = m_reg[i];
    @(negedge clk);
    check({tag, "_rd_valid"}, FLAT_W'(bus.rd_valid), FLAT_W'(e_rv));
    check({tag, "_err"},      FLAT_W'(bus.err),      FLAT_W'(e_err));
    if (bus.rd_valid && exp_q.size() > 0)
      check({tag, "_data_out"}, FLAT_W'(bus.data_out), FLAT_W'(exp_q.pop_front()));
    else
      check({tag, "_data_hold"}, FLAT_W'(bus.data_out), FLAT_W'(m_dout));
    check({tag, "_cfg_flat"}, bus.cfg_flat, model_flat());
  endtask

  task automatic wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] be);
    do_op(tag, 1'b1, 1'b0, a, d, be, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a);
    do_op(tag, 1'b0, 1'b1, a, '0, 2'b00, 1'b0);
  endtask

  task automatic idle(input string tag);
    do_op(tag, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    drive_idle();
    @(negedge clk);

    // Reset values, read back-to-back
    do_reset();
    for (int i = 0; i < NUM_REGS; i++) rd("rst_read", ADDR_W'(i));
    rd("rst_lock", 4'd8);
    idle("hold");
    check("rst_reg0_const", FLAT_W'(m_reg[0]), FLAT_W'(16'hFFFF));

    // Byte strobes
    wr("be_hi", 4'd3, 16'h1234, 2'b10);
    rd("be_hi_rd", 4'd3);
    check("be_hi_const", FLAT_W'(m_reg[3]), FLAT_W'(16'h1200));
    wr("be_lo", 4'd3, 16'h00AA, 2'b01);
    rd("be_lo_rd", 4'd3);
    wr("be_none", 4'd3, 16'h5555, 2'b00);
    rd("be_none_rd", 4'd3);
    // Write then read same address on the next cycle
    wr("raw_wr", 4'd1, 16'hC0DE, 2'b11);
    rd("raw_rd", 4'd1);

    // Locks
    wr("lock_set", 4'd8, 16'h0004, 2'b00);
    wr("lock_wr", 4'd2, 16'h5555, 2'b11);
    rd("lock_rd2", 4'd2);
    rd("lock_rd8", 4'd8);
    wr("lock_more", 4'd8, 16'hFF01, 2'b11);
    wr("lock_sticky", 4'd8, 16'h0000, 2'b11);
    rd("lock_rd8b", 4'd8);
    wr("lock_wr0", 4'd0, 16'h0BAD, 2'b11);
    do_reset();
    wr("unlock_wr", 4'd2, 16'h5555, 2'b11);
    rd("unlock_rd", 4'd2);

    // Error cases
    wr("oor_wr", 4'd9, 16'h7777, 2'b11);
    rd("oor_rd", 4'd9);
    rd("oor_rd15", 4'd15);
    do_op("collide", 1'b1, 1'b1, 4'd4, 16'h4444, 2'b11, 1'b0);
    rd("collide_rd", 4'd4);
    idle("hold2");

    // Shadow/commit (in the default build commit must have no effect)
    wr("sh_wr", 4'd6, 16'hBEEF, 2'b11);
    rd("sh_rd", 4'd6);
    do_op("sh_commit", 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1);
    do_op("sh_wr_commit", 1'b1, 1'b0, 4'd5, 16'h1357, 2'b11, 1'b1);
    wr("sh_wr2", 4'd7, 16'h2468, 2'b11);
    idle("sh_idle");

    // Random writes then reads
    do_reset();
    for (int n = 0; n < 8; n++)
      wr("rnd_wr", ADDR_W'($urandom_range(0, NUM_REGS-1)), DATA_W'($urandom), 2'($urandom_range(1, 3)));
    for (int i = 0; i < NUM_REGS; i++) rd("rnd_rd", ADDR_W'(i));

    // Random mixed traffic including locks, commits, out-of-range and collisions
    for (int n = 0; n < 150; n++) begin
      logic [ADDR_W-1:0] a;
      logic              w, r;
      a = ADDR_W'($urandom_range(0, 10));
      if ($urandom_range(0, 15) == 0) a = 4'd8;
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      if (a == 4'd8 && w) begin
        // Keep locks sparse so most writes stay meaningful.
        do_op("mix_lock", 1'b1, r, a, DATA_W'(1 << $urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else begin
        do_op("mix", w, r, a, DATA_W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      end
    end
    idle("final_idle");
    check("exp_q_empty", FLAT_W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
